tape_note_sequencer: RTL and testbench

Playback sequencer that sits directly downstream of the 8x1024 note memory. It walks the memory address space from address 0 and fetches one note byte per step. It presents each byte as a held note code to the tone generator for a fixed step duration. It stops at an end-of-song marker or at the last address, or restarts when loop mode is on.

---
 rtl/tape_note_sequencer.sv | 141 ++++++++++++++
 tb/tb_tape_note_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tape_note_sequencer
// Brief    : Walks a note memory from address 0 and holds each fetched byte
//            as a note code for a fixed step; stops or loops at end of song.
// Revision : 1.0 - initial release
// ============================================================================
module tape_note_sequencer #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 8,
  parameter int                STEP_TICKS = 12500000,
  parameter logic [DATA_W-1:0] END_CODE   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] note_code,
  output logic              note_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int                  c_TIMER_W   = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
  // FETCH and CAPTURE consume two cycles of every step, so HOLD runs STEP_TICKS-2.
  localparam logic [c_TIMER_W-1:0] c_TICK_LAST = c_TIMER_W'(STEP_TICKS - 3);
  localparam logic [ADDR_W-1:0]    c_ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_ptr;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [ADDR_W-1:0]    r_cur_addr;
  logic [DATA_W-1:0]    r_note;
  logic                 r_note_valid;
  logic                 r_read_en;
  logic                 r_busy;
  logic                 r_done;
  logic [c_TIMER_W-1:0] r_timer;

  logic w_step_end;
  logic w_eos;

  assign w_step_end = (r_state == S_HOLD) && !pause && (r_timer == c_TICK_LAST);
  assign w_eos      = ((r_state == S_CAPTURE) && (mem_data == END_CODE)) ||
                      (w_step_end && (r_ptr == c_ADDR_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_mem_addr   <= '0;
      r_cur_addr   <= '0;
      r_note       <= '0;
      r_note_valid <= 1'b0;
      r_read_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_read_en <= 1'b0;
      if ((r_state != S_IDLE) && stop) begin
        r_state      <= S_IDLE;
        r_note       <= '0;
        r_note_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else if (w_eos) begin
        if (loop_en) begin
          r_ptr      <= '0;
          r_mem_addr <= '0;
          r_read_en  <= 1'b1;
          r_state    <= S_FETCH;
        end else begin
          r_note       <= '0;
          r_note_valid <= 1'b0;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (play) begin
              r_ptr      <= '0;
              r_mem_addr <= '0;
              r_read_en  <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            r_state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            r_note       <= mem_data;
            r_note_valid <= (mem_data != '0);
            r_cur_addr   <= r_ptr;
            r_timer      <= '0;
            r_state      <= S_HOLD;
          end
          S_HOLD: begin
            if (w_step_end) begin
              r_ptr      <= r_ptr + 1'b1;
              r_mem_addr <= r_ptr + 1'b1;
              r_read_en  <= 1'b1;
              r_state    <= S_FETCH;
            end else if (!pause) begin
              r_timer <= r_timer + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_read_en  = r_read_en;
  assign mem_write_en = 1'b0;
  assign mem_addr     = r_mem_addr;
  assign note_code    = r_note;
  assign note_valid   = r_note_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cur_addr     = r_cur_addr;

endmodule
`default_nettype wire

// File: tb/tb_tape_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tape_note_sequencer
// Brief    : Scoreboard bench; a song-level timeline model queues expected
//            fetches, notes and end events, and a monitor checks each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tape_note_sequencer;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int ST    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int PZN   = 512;

  localparam int K_FETCH = 0;
  localparam int K_NOTE  = 1;
  localparam int K_DONE  = 2;
  localparam int K_IDLE  = 3;

  typedef struct {
    int kind;
    int cyc;
    int addr;
    int code;
    bit rstchk;
  } ev_t;

  ev_t sb[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          play;
  logic          stop;
  logic          pause;
  logic          loop_en;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] note_code;
  logic          note_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_addr;

  logic [7:0] mem [DEPTH];
  int pz [PZN];
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int exp_hold = 0;
  bit exp_busy = 1'b0;
  bit mon_en   = 1'b0;

  tape_note_sequencer #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STEP_TICKS(ST),
    .END_CODE  (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .play        (play),
    .stop        (stop),
    .pause       (pause),
    .loop_en     (loop_en),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .note_code   (note_code),
    .note_valid  (note_valid),
    .busy        (busy),
    .done        (done),
    .cur_addr    (cur_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    mem_data <= (mem_read_en === 1'b1) ? mem[mem_addr] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input int k, input int c, input int a, input int d, input bit r);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.code = d; e.rstchk = r;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missed_event kind=%0d actual=absent required_cyc=%0d", sb[0].kind, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (mem_read_en !== 1'b0) begin
        if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].kind == K_FETCH) begin
          e = sb.pop_front();
          chk("fetch_addr", mem_addr, e.addr);
          exp_busy = 1'b1;
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_fetch cyc=%0d actual_addr=%0d required=no_read", cyc, mem_addr);
        end
      end
      if (done !== 1'b0) begin
        if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].kind == K_DONE) begin
          void'(sb.pop_front());
          checks++;
          exp_hold = 0;
          exp_busy = 1'b0;
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_done cyc=%0d actual=%0b required=0", cyc, done);
        end
      end
      if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].kind == K_NOTE) begin
        e = sb.pop_front();
        chk("cur_addr", cur_addr, e.addr);
        exp_hold = e.code;
      end
      if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].kind == K_IDLE) begin
        e = sb.pop_front();
        exp_hold = 0;
        exp_busy = 1'b0;
        chk("idle_read_en", mem_read_en, 0);
        chk("idle_done", done, 0);
        if (e.rstchk) begin
          chk("rst_cur_addr", cur_addr, 0);
          chk("rst_mem_addr", mem_addr, 0);
        end
      end
      chk("note_code", note_code, exp_hold);
      chk("note_valid", note_valid, (exp_hold != 0));
      chk("busy", busy, exp_busy);
      chk("write_en", mem_write_en, 0);
    end
  end

  task automatic fill_pause(input int density);
    for (int i = 0; i < PZN; i++) pz[i] = ($urandom_range(0, 99) < density) ? 1 : 0;
  endtask

  // Builds the expected song timeline from the memory image, then plays it.
  task automatic run_song(input bit lp, input int stop_off, input bit rst_stop, input bit rand_play);
    int  p, s, t, f, c, n, ptr, d, endc;
    @(negedge clk);
    p    = cyc;
    s    = (stop_off >= 0) ? p + stop_off : 32'h3fff_ffff;
    ptr  = 0;
    t    = p + 1;
    endc = -1;
    while (1) begin
      f = t;
      if (f > s) break;
      push_ev(K_FETCH, f, ptr, 0, 1'b0);
      if (mem[ptr] == 8'hFF) begin
        if (lp) begin ptr = 0; t = f + 2; continue; end
        d = f + 2;
        if (d <= s) begin push_ev(K_DONE, d, 0, 0, 1'b0); endc = d; end
        break;
      end
      if (f + 2 > s) break;
      push_ev(K_NOTE, f + 2, ptr, mem[ptr], 1'b0);
      c = f + 2;
      n = 0;
      forever begin
        if (c - p >= PZN || pz[c - p] == 0) begin
          n++;
          if (n == ST - 2) break;
        end
        c++;
      end
      if (ptr == DEPTH - 1) begin
        if (lp) begin ptr = 0; t = c + 1; continue; end
        d = c + 1;
        if (d <= s) begin push_ev(K_DONE, d, 0, 0, 1'b0); endc = d; end
        break;
      end
      ptr++;
      t = c + 1;
    end
    if (endc < 0) begin
      endc = s + 1;
      push_ev(K_IDLE, s + 1, 0, 0, rst_stop);
    end

    loop_en = lp;
    for (int e = p; e <= endc + 2; e++) begin
      if (e != p) @(negedge clk);
      play  = (e == p) || (rand_play && e > p && e < endc && $urandom_range(0, 15) == 0);
      stop  = (e == s) && !rst_stop;
      rst   = (e == s) && rst_stop;
      if (rst_stop && e == s) play = 1'b1;
      pause = (e - p < PZN) && (pz[e - p] != 0);
    end
    @(negedge clk);
    play = 1'b0; stop = 1'b0; rst = 1'b0; pause = 1'b0;
    #1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain cyc=%0d actual_pending=%0d required=0", cyc, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    for (int i = 0; i < PZN; i++) pz[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_note_code", note_code, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_read_en", mem_read_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cur_addr", cur_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_write_en", mem_write_en, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // basic song with a rest and an end marker
    mem[0] = 8'h3C; mem[1] = 8'h00; mem[2] = 8'h40; mem[3] = 8'hFF;
    for (int i = 4; i < DEPTH; i++) mem[i] = 8'h55;
    run_song(1'b0, -1, 1'b0, 1'b0);
    run_song(1'b1, 60, 1'b0, 1'b0);
    for (int i = 4; i < 24; i++) pz[i] = 1;
    run_song(1'b0, -1, 1'b0, 1'b0);
    for (int i = 0; i < PZN; i++) pz[i] = 0;
    run_song(1'b0, 1, 1'b0, 1'b0);
    run_song(1'b0, -1, 1'b0, 1'b0);

    // no end marker: runs to the last address
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h11;
    run_song(1'b0, -1, 1'b0, 1'b0);
    run_song(1'b1, 100, 1'b0, 1'b0);

    // reset during HOLD with play held high
    run_song(1'b0, 5, 1'b1, 1'b0);
    run_song(1'b0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      bit lp;
      int so;
      for (int i = 0; i < DEPTH; i++) begin
        int k;
        k = $urandom_range(0, 9);
        mem[i] = (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : 8'($urandom_range(1, 254));
      end
      lp = 1'($urandom_range(0, 1));
      so = (lp || $urandom_range(0, 2) == 0) ? $urandom_range(1, 150) : -1;
      fill_pause($urandom_range(0, 40));
      run_song(lp, so, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
